// File: rtl/sync_fifo_top.sv
// Single-clock FIFO with wrap-bit pointers and a registered read port.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_top #(
    parameter int DATA_WIDTH    = 4,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] fifo_in,
    output logic [DATA_WIDTH-1:0] fifo_out,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int PTR_W = ADDRESS_WIDTH + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wptr_r;
    logic [PTR_W-1:0]      rptr_r;
    logic [DATA_WIDTH-1:0] fifo_out_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;

    // Flag decode from the registered pointers and acceptance qualification.
    always_comb begin
        empty_s     = (wptr_r == rptr_r);
        full_s      = (wptr_r[ADDRESS_WIDTH-1:0] == rptr_r[ADDRESS_WIDTH-1:0]) &&
                      (wptr_r[ADDRESS_WIDTH] != rptr_r[ADDRESS_WIDTH]);
        // A read frees a slot in the same edge, so a full FIFO can still take a write.
        wr_accept_s = write_en & (~full_s | read_en);
        rd_accept_s = read_en & ~empty_s;
    end

    // Storage array; deliberately not reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_accept_s && !reset) begin
            mem_r[wptr_r[ADDRESS_WIDTH-1:0]] <= fifo_in;
        end
    end

    // Pointer and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r     <= {PTR_W{1'b0}};
            rptr_r     <= {PTR_W{1'b0}};
            fifo_out_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (wr_accept_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (rd_accept_s) begin
                fifo_out_r <= mem_r[rptr_r[ADDRESS_WIDTH-1:0]];
                rptr_r     <= rptr_r + PTR_ONE;
            end
        end
    end

    assign fifo_out = fifo_out_r;
    assign full     = full_s;
    assign empty    = empty_s;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (write_en && full_s && !read_en) begin
                overflow_r <= 1'b1;
            end
            if (read_en && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`endif

endmodule

// File: tb/tb_sync_fifo_top.sv
// Directed self-checking bench for sync_fifo_top (default 4-bit x 16 configuration).
module tb_sync_fifo_top;

    logic       clk;
    logic       reset;
    logic       write_en;
    logic       read_en;
    logic [3:0] fifo_in;
    logic [3:0] fifo_out;
    logic       full;
    logic       empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int total_cnt;
    int bad_cnt;

    sync_fifo_top #(.DATA_WIDTH(4), .ADDRESS_WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .write_en (write_en),
        .read_en  (read_en),
        .fifo_in  (fifo_in),
        .fifo_out (fifo_out),
        .full     (full),
        .empty    (empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq8 [8];
    logic [3:0] d;
    logic [3:0] prev_d;

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        seq8[0] = 4'h6; seq8[1] = 4'h5; seq8[2] = 4'h4; seq8[3] = 4'h3;
        seq8[4] = 4'h2; seq8[5] = 4'h1; seq8[6] = 4'h0; seq8[7] = 4'h8;

        // Reset for 3 cycles with write_en held high.
        reset = 1'b1; write_en = 1'b1; read_en = 1'b0; fifo_in = 4'h7;
        for (int i = 0; i < 3; i++) tick();
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_out", 32'(fifo_out), 32'h0);
        reset = 1'b0; write_en = 1'b0;
        tick();
        check_val("post_rst_empty", 32'(empty), 32'd1);

        // Eight writes, idle, then ten reads.
        for (int i = 0; i < 8; i++) begin
            write_en = 1'b1; fifo_in = seq8[i];
            tick();
            check_val("w8_empty", 32'(empty), 32'd0);
        end
        write_en = 1'b0;
        tick();
        read_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("r8_out", 32'(fifo_out), 32'(i < 8 ? seq8[i] : 4'h8));
            check_val("r8_empty", 32'(empty), 32'(i >= 7));
        end
        read_en = 1'b0;

        // Fill to 16, 17th write dropped, read back exactly 0..F.
        for (int i = 0; i < 16; i++) begin
            write_en = 1'b1; fifo_in = 4'(i);
            tick();
            check_val("fill_full", 32'(full), 32'(i == 15));
        end
        fifo_in = 4'hA;
        tick();
        check_val("ovf_full", 32'(full), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        check_val("ovf_flag", 32'(overflow), 32'd1);
`endif
        write_en = 1'b0; read_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_val("drain_out", 32'(fifo_out), 32'(i));
        end
        check_val("drain_empty", 32'(empty), 32'd1);
        read_en = 1'b0;

        // Full FIFO with simultaneous write+read for 4 cycles.
        for (int i = 0; i < 16; i++) begin
            write_en = 1'b1; fifo_in = 4'(i);
            tick();
        end
        read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fifo_in = 4'(4'hA + 4'(i));
            tick();
            check_val("wr_rd_full", 32'(full), 32'd1);
            check_val("wr_rd_out", 32'(fifo_out), 32'(i));
        end
        write_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_val("repl_out", 32'(fifo_out), 32'(i < 12 ? 4'(i + 4) : 4'(4'hA + 4'(i - 12))));
        end
        check_val("repl_empty", 32'(empty), 32'd1);
        read_en = 1'b0;

        // 40 words streamed through pointer wrap; first write hits an empty FIFO.
        prev_d = 4'h0;
        for (int k = 0; k < 40; k++) begin
            d = 4'((k * 3 + 1) & 15);
            write_en = 1'b1; read_en = (k != 0); fifo_in = d;
            tick();
            check_val("stream_full", 32'(full), 32'd0);
            check_val("stream_empty", 32'(empty), 32'd0);
            if (k != 0) check_val("stream_out", 32'(fifo_out), 32'(prev_d));
            prev_d = d;
        end
        write_en = 1'b0; read_en = 1'b1;
        tick();
        check_val("stream_last", 32'(fifo_out), 32'(prev_d));
        check_val("stream_end_empty", 32'(empty), 32'd1);
        read_en = 1'b0;

        // Reset with 5 words stored, then a read that must be ignored.
        for (int i = 0; i < 5; i++) begin
            write_en = 1'b1; fifo_in = 4'(i + 9);
            tick();
        end
        write_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid_rst_empty", 32'(empty), 32'd1);
        check_val("mid_rst_full", 32'(full), 32'd0);
        check_val("mid_rst_out", 32'(fifo_out), 32'h0);
`ifdef FIFO_ERR_FLAGS_EN
        check_val("mid_rst_ovf", 32'(overflow), 32'd0);
        check_val("mid_rst_udf", 32'(underflow), 32'd0);
`endif
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check_val("udf_out", 32'(fifo_out), 32'h0);
        check_val("udf_empty", 32'(empty), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        check_val("udf_flag", 32'(underflow), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
